// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
//   Board timing constants shared by the key conditioning path, plus the
//   helper that turns a debounce time into a clock-cycle count.
//   Contents:
//     CLK_HZ                   board clock frequency (CLOCK_50)
//     DEBOUNCE_MS              debounce window in milliseconds
//     debounce_cycles()        cycles for a window of ms milliseconds
//     DEBOUNCE_CYCLES_DFLT     default cycle count derived from the above
package key_debounce_pkg;

  localparam int CLK_HZ      = 32'd50_000_000;
  localparam int DEBOUNCE_MS = 32'd10;

  // Cycle count for a debounce window; divide first so the product never overflows.
  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DFLT = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Bundles the raw key pins and the conditioned key outputs.
//   Signals (all N_KEYS wide):
//     key_n        raw pins, active-low, asynchronous to clk
//     key_level    debounced level, active-high
//     key_press    1-cycle strobe on accepted press
//     key_release  1-cycle strobe on accepted release
//   Modports:
//     master  the pin side / consumer: drives key_n, observes the outputs
//     slave   the debouncer: reads key_n, drives the outputs
interface key_debounce_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
//   One key channel: synchronizer chain, stability counter, debounced level
//   and press/release strobes. All outputs are registered.
//   Ports:
//     clk          system clock
//     reset        synchronous, active-high
//     key_n        raw pin, active-low, asynchronous
//     key_level    debounced level, active-high
//     key_press    1-cycle strobe when the level is accepted as 1
//     key_release  1-cycle strobe when the level is accepted as 0
module key_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   press_r;
  logic                   release_r;
  logic                   pressed_s;

  // Last synchronizer stage, inverted so 1 means pressed.
  assign pressed_s = ~sync_r[SYNC_STAGES-1];

  // Synchronize the pin and accept a new level once it has held long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r    <= '1;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], key_n};
      press_r   <= 1'b0;
      release_r <= 1'b0;
      if (pressed_s == level_r) begin
        // Back at the accepted level: any partial count is a bounce.
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        // Cleared on acceptance, so the counter never needs to saturate.
        level_r   <= pressed_s;
        cnt_r     <= '0;
        press_r   <= pressed_s;
        release_r <= ~pressed_s;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
//   Conditions the raw, bouncy, active-low push-buttons for the control path.
//   One independent key_debounce_ch per key; simultaneous events on several
//   keys yield simultaneous strobes.
//   Ports:
//     clk    system clock (CLOCK_50)
//     reset  synchronous, active-high
//     keys   key_debounce_if slave: key_n in; key_level, key_press,
//            key_release out. The interface N_KEYS must equal N_KEYS here.
//   Parameters:
//     N_KEYS           number of key channels
//     SYNC_STAGES      synchronizer depth, at least 2
//     DEBOUNCE_CYCLES  cycles a new level must hold before acceptance, at least 1
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input logic           clk,
  input logic           reset,
  key_debounce_if.slave keys
);

  logic [N_KEYS-1:0] level_s;
  logic [N_KEYS-1:0] press_s;
  logic [N_KEYS-1:0] release_s;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .key_n       (keys.key_n[i]),
      .key_level   (level_s[i]),
      .key_press   (press_s[i]),
      .key_release (release_s[i])
    );
  end

  assign keys.key_level   = level_s;
  assign keys.key_press   = press_s;
  assign keys.key_release = release_s;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
//   N_KEYS=4. Expected outputs are queued with the cycle they are due at
//   when stimulus is applied, and compared once that cycle's edge has passed.
//   A raw change applied after edge c is first sampled at edge c+1 and is
//   accepted at edge c+1+SYNC_STAGES+DEBOUNCE_CYCLES-1 = c+6.
module tb_key_debounce;

  localparam int NK = 4;

  typedef struct {
    int          cyc;
    logic [3:0]  lv;
    logic [3:0]  pr;
    logic [3:0]  rl;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  key_debounce_if #(.N_KEYS(NK)) kif ();

  key_debounce #(
    .N_KEYS          (NK),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string tag, input string field, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s.%s cyc=%0d observed=%b expected=%b", tag, field, cyc, obs, expv);
  endtask

  task automatic push_exp(input int off, input logic [3:0] lv, input logic [3:0] pr,
                          input logic [3:0] rl, input string tag);
    exp_t e;
    e.cyc = cyc + off;
    e.lv  = lv;
    e.pr  = pr;
    e.rl  = rl;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare every expectation that has come due.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check4(e.tag, "level",   kif.key_level,   e.lv);
      check4(e.tag, "press",   kif.key_press,   e.pr);
      check4(e.tag, "release", kif.key_release, e.rl);
    end
  endtask

  task automatic hold(input int n, input logic [3:0] lv, input string tag);
    for (int k = 0; k < n; k++) begin
      push_exp(1, lv, 4'b0000, 4'b0000, tag);
      tick();
    end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    kif.key_n = 4'b0000;

    // 1. Reset with all keys held, then debounce them as fresh presses.
    hold(3, 4'b0000, "reset");
    reset = 1'b0;
    push_exp(5, 4'b0000, 4'b0000, 4'b0000, "rst_pre");
    push_exp(6, 4'b1111, 4'b1111, 4'b0000, "rst_acc");
    push_exp(7, 4'b1111, 4'b0000, 4'b0000, "rst_post");
    repeat (7) tick();

    // Release keys 0 and 1 to set up the press tests.
    kif.key_n = 4'b0011;
    push_exp(5, 4'b1111, 4'b0000, 4'b0000, "rel01_pre");
    push_exp(6, 4'b1100, 4'b0000, 4'b0011, "rel01_acc");
    push_exp(7, 4'b1100, 4'b0000, 4'b0000, "rel01_post");
    repeat (7) tick();

    // 2. Clean press on key 0.
    kif.key_n = 4'b0010;
    push_exp(5, 4'b1100, 4'b0000, 4'b0000, "press0_pre");
    push_exp(6, 4'b1101, 4'b0001, 4'b0000, "press0_acc");
    push_exp(7, 4'b1101, 4'b0000, 4'b0000, "press0_post");
    repeat (8) tick();

    // 3. Key 1 bounces 0,1,0,1 with 3-cycle dwell, then settles pressed.
    for (int k = 0; k < 4; k++) begin
      kif.key_n[1] = (k % 2 == 1) ? 1'b1 : 1'b0;
      hold(3, 4'b1101, "bounce");
    end
    kif.key_n[1] = 1'b0;
    push_exp(5, 4'b1101, 4'b0000, 4'b0000, "bounce_pre");
    push_exp(6, 4'b1111, 4'b0010, 4'b0000, "bounce_acc");
    push_exp(7, 4'b1111, 4'b0000, 4'b0000, "bounce_post");
    repeat (7) tick();

    // 4. Key 2 glitches released for 3 cycles: must be discarded.
    kif.key_n[2] = 1'b1;
    hold(3, 4'b1111, "glitch");
    kif.key_n[2] = 1'b0;
    hold(8, 4'b1111, "glitch_after");

    // 5. Keys 3 and 2 released on the same edge.
    kif.key_n = 4'b1100;
    push_exp(5, 4'b1111, 4'b0000, 4'b0000, "rel32_pre");
    push_exp(6, 4'b0011, 4'b0000, 4'b1100, "rel32_acc");
    push_exp(7, 4'b0011, 4'b0000, 4'b0000, "rel32_post");
    repeat (8) tick();

    // 6. Key 3 pressed, reset pulsed with its counter at 2, key still held.
    kif.key_n = 4'b0100;
    hold(4, 4'b0011, "mid_count");
    reset = 1'b1;
    push_exp(1, 4'b0000, 4'b0000, 4'b0000, "mid_reset");
    tick();
    reset = 1'b0;
    push_exp(5, 4'b0000, 4'b0000, 4'b0000, "mid_pre");
    push_exp(6, 4'b1011, 4'b1011, 4'b0000, "mid_acc");
    push_exp(7, 4'b1011, 4'b0000, 4'b0000, "mid_post");
    repeat (7) tick();

    if (sb.size() != 0) begin
      n_checks++;
      $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
